class_router: RTL
=================

Name: class_router

Overview:
- Parametrised successor to the transaction-layer class referee.
- Drains one FWFT input FIFO and steers each word to one of NUM_CLASSES class FIFOs, selected by the class field in the word.
- Backpressure is per destination, or legacy global via parameter. Full throughput is one word per clock.
- Keeps saturating per-class word counters for debug. Sits between the TX input FIFO and the per-class (VC) FIFOs.

Parameters:
- DATA_W, 12, word width.
- NUM_CLASSES, 4, destination FIFOs; power of two, 2..16. CLASS_W = log2(NUM_CLASSES).
- CLASS_LSB, 10, LSB of the class field data_in[CLASS_LSB+CLASS_W-1:CLASS_LSB]. Field must fit in DATA_W.
- GLOBAL_BP, 0, backpressure mode. 0 = stall only when the destination is almost_full. 1 = stall when any destination is almost_full.
- CNT_W, 8, width of each per-class counter.

Ports:
- clk  in  1  clock
- reset_L  in  1  async active-low reset
- state  in  4  one-hot link state: 0001 RESET, 0010 INIT, 0100 IDLE, 1000 ACTIVE
- data_in  in  DATA_W  head word of input FIFO (FWFT, valid while !empty)
- empty  in  1  input FIFO empty
- almost_full  in  NUM_CLASSES  per-class almost_full, bit i = class i
- pop  out  1  input FIFO read strobe, combinational
- push  out  NUM_CLASSES  one-hot write strobe to class FIFOs, registered
- data_out  out  DATA_W  word accompanying push, registered
- cnt_out  out  NUM_CLASSES*CNT_W  per-class pushed-word counters, class i at [i*CNT_W +: CNT_W]
- busy  out  1  push pending or pop this cycle

Behaviour:
- reset_L=0, asynchronous: push=0, data_out=0, all counters=0, pending=0. pop=0 while reset_L=0.
- state==RESET (synchronous flush): same clears as reset_L on each clk; pop forced 0.
- Routing is enabled only in IDLE or ACTIVE. In INIT or any non-one-hot value, pop=0, push=0 next cycle, counters hold.
- dest = class field of data_in.
- blocked = almost_full[dest] when GLOBAL_BP=0; blocked = |almost_full when GLOBAL_BP=1.
- pop = enabled & ~empty & ~blocked & reset_L. This is the only combinational output.
- Edge after a pop=1 cycle: push <= (1<<dest), data_out <= data_in, counter[dest] increments.
- Edge after a pop=0 cycle: push <= 0, data_out holds.
- Latency: pop in cycle N gives push in cycle N+1. Back-to-back pops allowed, up to one word/clk.
- Data ordering is preserved; there is no reordering across classes.
- A blocked head word stalls the whole stream (head-of-line blocking, intended). No drop and no skip.
- almost_full must assert with ≥1 free slot, because one word can be in flight after almost_full rises.
- Counters saturate at 2^CNT_W-1 and do not wrap. They clear only on reset_L or state RESET.
- busy = pop | (|push).
- State leaves IDLE/ACTIVE while a push is pending: that push still completes next cycle. No new pop.
- State enters RESET while a push is pending: the pending push is cancelled (push=0). The destination FIFO is flushed by the same state, so no word is lost that matters.
- empty and almost_full[dest] change in the same cycle: pop follows current inputs only. There is no lookahead.

Decomposition:
- Shared package tl_pkg holds:
  - state encodings ST_RESET/ST_INIT/ST_IDLE/ST_ACTIVE
  - a clog2 function
  - the default DATA_W, CLASS_LSB and NUM_CLASSES constants, shared with the VC FIFOs
- One sub-module, class_counter: CNT_W saturating counter with sync clear and inc. It is instantiated NUM_CLASSES times via generate.
- Decode, pop logic and the push/data register stay in class_router.

Test Plan:
- Reset: reset_L=0 mid-stream with push=0010 → push=0, cnt_out=0, pop=0 immediately, without waiting for a clk.
- Streaming: ACTIVE, 4 words with classes 0,1,2,3 (data 0x012,0x456,0x89A,0xCDE), no almost_full → pop high 4 consecutive cycles; push=0001,0010,0100,1000 one cycle later with matching data_out; each counter=1.
- Per-class backpressure, GLOBAL_BP=0: almost_full=0100, head class 2 → pop=0, stream stalls. Head class 1 with almost_full=0100 → pops. Drop almost_full → class-2 word pushed.
- Global mode, GLOBAL_BP=1: almost_full=1000, head class 0 → pop=0. Clear it → pop=1 the same cycle.
- Saturation, CNT_W=2: 5 class-3 words → cnt_out[3]=3. state=0001 for one clk → all counters 0.
- State gating: pop in ACTIVE then state=INIT next cycle → that word's push still occurs, and no further pops in INIT even with !empty. 12-bit and NUM_CLASSES=8, DATA_W=16, CLASS_LSB=13 builds both pass the streaming test.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared transaction-layer definitions: link state encodings, default widths
// used by the router and the VC FIFOs, and a constant log2 helper.
package tl_pkg;

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } link_state_e;

  localparam int TL_DATA_W      = 12;
  localparam int TL_CLASS_LSB   = 10;
  localparam int TL_NUM_CLASSES = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/class_router_if.sv
// Router data path: FWFT input FIFO head/empty/pop plus class FIFO push/data
// and their almost_full flags. master = router side, slave = FIFO side.
interface class_router_if #(
  parameter int DATA_W      = tl_pkg::TL_DATA_W,
  parameter int NUM_CLASSES = tl_pkg::TL_NUM_CLASSES
) ();

  logic [DATA_W-1:0]      data_in;
  logic                   empty;
  logic [NUM_CLASSES-1:0] almost_full;
  logic                   pop;
  logic [NUM_CLASSES-1:0] push;
  logic [DATA_W-1:0]      data_out;

  modport master (
    input  data_in, empty, almost_full,
    output pop, push, data_out
  );

  modport slave (
    output data_in, empty, almost_full,
    input  pop, push, data_out
  );

endinterface

// File: rtl/class_counter.sv
// Saturating debug counter with synchronous clear; clear wins over increment.
module class_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/class_router.sv
// Steers each word of the FWFT input FIFO to the class FIFO named by its class
// field; one word per clock, head-of-line blocking on almost_full.
module class_router import tl_pkg::*; #(
  parameter int DATA_W      = TL_DATA_W,
  parameter int NUM_CLASSES = TL_NUM_CLASSES,
  parameter int CLASS_LSB   = TL_CLASS_LSB,
  parameter int GLOBAL_BP   = 0,
  parameter int CNT_W       = 8
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic [3:0]                   state,
  class_router_if.master               bus,
  output logic [NUM_CLASSES*CNT_W-1:0] cnt_out,
  output logic                         busy
);

  localparam int CLASS_W = clog2(NUM_CLASSES);

  logic [CLASS_W-1:0]     dest;
  logic [NUM_CLASSES-1:0] dest_onehot;
  logic                   enabled;
  logic                   flush;
  logic                   blocked;
  logic                   pop;
  logic [NUM_CLASSES-1:0] push_d;
  logic [NUM_CLASSES-1:0] push_q;
  logic [DATA_W-1:0]      data_d;
  logic [DATA_W-1:0]      data_q;

  always_comb begin
    dest        = bus.data_in[CLASS_LSB +: CLASS_W];
    dest_onehot = '0;
    dest_onehot[dest] = 1'b1;
    // Non-one-hot state values match neither IDLE nor ACTIVE, so they gate routing.
    enabled = (state == ST_IDLE) || (state == ST_ACTIVE);
    flush   = (state == ST_RESET);
    blocked = (GLOBAL_BP != 0) ? (|bus.almost_full) : bus.almost_full[dest];
    pop     = enabled & ~bus.empty & ~blocked & reset_L;
    push_d  = pop ? dest_onehot : '0;
    data_d  = pop ? bus.data_in : data_q;
    if (flush) begin
      push_d = '0;
      data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      push_q <= '0;
      data_q <= '0;
    end else begin
      push_q <= push_d;
      data_q <= data_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_cnt
    class_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .reset_L (reset_L),
      .clr     (flush),
      .inc     (pop & dest_onehot[gi]),
      .count   (cnt_out[gi*CNT_W +: CNT_W])
    );
  end

  assign bus.pop      = pop;
  assign bus.push     = push_q;
  assign bus.data_out = data_q;
  assign busy         = pop | (|push_q);

endmodule
